// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Provides:
// - the controller state enum
// - the forwarding-select encodings
// - the register-0 index
package pipe_ctrl_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Forwarding select encodings
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // Register 0 always reads as zero and is never a forwarding target
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one ID source field.
// Ports:
//   i_src, i_use                - source register and its use flag
//   i_ex_rd, i_ex_rf_le, i_ex_l - EX destination, write enable, load flag
//   i_mem_rd, i_mem_rf_le       - MEM destination, write enable
//   i_wb_rd, i_wb_rf_le         - WB destination, write enable
//   o_sel                       - select: RF / EX / MEM / WB
module fwd_select
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_use,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_rf_le,
    input  logic       i_ex_l,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_rf_le,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_rf_le,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_use && (i_src != REG_ZERO)) begin
            // A load in EX has no data yet; the stall logic covers that case,
            // so EX is skipped and an older match may be chosen instead.
            if (i_ex_rf_le && !i_ex_l && (i_ex_rd == i_src))
                o_sel = FWD_EX;
            else if (i_mem_rf_le && (i_mem_rd == i_src))
                o_sel = FWD_MEM;
            else if (i_wb_rf_le && (i_wb_rd == i_src))
                o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the five-stage pipeline.
// The controller does the following:
// - Runs a boot hold after reset.
// - Resolves taken-branch flushes and load-use stalls.
// - Selects forwarding sources for RA, RB and the store data.
// - Keeps saturating stall and flush event counters.
// Ports:
//   Clk, Rst                      - clock, synchronous active-high reset
//   ID_RA/RB/RD, ID_USE_RA/RB/RD  - ID source fields and use flags
//   EX_RD, EX_RF_LE, EX_L         - EX destination, write enable, load flag
//   MEM_RD, MEM_RF_LE             - MEM destination, write enable
//   WB_RD, WB_RF_LE               - WB destination, write enable
//   EX_TAKEN                      - taken branch/jump resolved in EX
//   PC_LE, IF_ID_LE, IF_ID_CLR    - fetch-side load/clear controls
//   CU_NOP                        - inject NOP into ID/EX
//   FWD_RA/RB/RD                  - forwarding selects
//   STALL_CNT, FLUSH_CNT          - saturating event counters
//   BUSY_BOOT                     - high while in BOOT
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       ID_RA,
    input  logic [4:0]       ID_RB,
    input  logic [4:0]       ID_RD,
    input  logic             ID_USE_RA,
    input  logic             ID_USE_RB,
    input  logic             ID_USE_RD,
    input  logic [4:0]       EX_RD,
    input  logic             EX_RF_LE,
    input  logic             EX_L,
    input  logic [4:0]       MEM_RD,
    input  logic             MEM_RF_LE,
    input  logic [4:0]       WB_RD,
    input  logic             WB_RF_LE,
    input  logic             EX_TAKEN,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             IF_ID_CLR,
    output logic             CU_NOP,
    output logic [1:0]       FWD_RA,
    output logic [1:0]       FWD_RB,
    output logic [1:0]       FWD_RD,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT,
    output logic             BUSY_BOOT
);

    localparam logic [3:0]       BOOT_INIT = 4'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           r_state;
    logic [3:0]       r_boot_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_busy_boot;

    logic w_run;
    logic w_load_use;
    logic w_flush;
    logic w_stall;

    assign w_run = (r_state == RUN);

    // Load-use: the loaded value is not available to forward this cycle.
    assign w_load_use = EX_L && EX_RF_LE && (EX_RD != REG_ZERO) &&
                        ((ID_USE_RA && (ID_RA == EX_RD)) ||
                         (ID_USE_RB && (ID_RB == EX_RD)) ||
                         (ID_USE_RD && (ID_RD == EX_RD)));

    // A taken branch squashes the stalled instruction, so it overrides load-use.
    assign w_flush = w_run && EX_TAKEN;
    assign w_stall = w_run && !EX_TAKEN && w_load_use;

    always_comb begin
        PC_LE     = 1'b1;
        IF_ID_LE  = 1'b1;
        IF_ID_CLR = 1'b0;
        CU_NOP    = 1'b0;
        if (!w_run) begin
            PC_LE     = 1'b0;
            IF_ID_LE  = 1'b0;
            IF_ID_CLR = 1'b1;
            CU_NOP    = 1'b1;
        end else if (w_flush) begin
            IF_ID_CLR = 1'b1;
            CU_NOP    = 1'b1;
        end else if (w_stall) begin
            PC_LE     = 1'b0;
            IF_ID_LE  = 1'b0;
            CU_NOP    = 1'b1;
        end
    end

    // Use flags are gated with RUN so all selects read RF during boot
    fwd_select u_fwd_ra (
        .i_src      (ID_RA),
        .i_use      (ID_USE_RA & w_run),
        .i_ex_rd    (EX_RD),
        .i_ex_rf_le (EX_RF_LE),
        .i_ex_l     (EX_L),
        .i_mem_rd   (MEM_RD),
        .i_mem_rf_le(MEM_RF_LE),
        .i_wb_rd    (WB_RD),
        .i_wb_rf_le (WB_RF_LE),
        .o_sel      (FWD_RA)
    );

    fwd_select u_fwd_rb (
        .i_src      (ID_RB),
        .i_use      (ID_USE_RB & w_run),
        .i_ex_rd    (EX_RD),
        .i_ex_rf_le (EX_RF_LE),
        .i_ex_l     (EX_L),
        .i_mem_rd   (MEM_RD),
        .i_mem_rf_le(MEM_RF_LE),
        .i_wb_rd    (WB_RD),
        .i_wb_rf_le (WB_RF_LE),
        .o_sel      (FWD_RB)
    );

    fwd_select u_fwd_rd (
        .i_src      (ID_RD),
        .i_use      (ID_USE_RD & w_run),
        .i_ex_rd    (EX_RD),
        .i_ex_rf_le (EX_RF_LE),
        .i_ex_l     (EX_L),
        .i_mem_rd   (MEM_RD),
        .i_mem_rf_le(MEM_RF_LE),
        .i_wb_rd    (WB_RD),
        .i_wb_rf_le (WB_RF_LE),
        .o_sel      (FWD_RD)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= BOOT;
            r_boot_cnt  <= BOOT_INIT;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_busy_boot <= 1'b1;
        end else begin
            case (r_state)
                BOOT: begin
                    if (r_boot_cnt == 4'd0) begin
                        r_state     <= RUN;
                        r_busy_boot <= 1'b0;
                    end else begin
                        r_boot_cnt <= r_boot_cnt - 4'd1;
                    end
                end
                RUN: begin
                    if (w_stall && (r_stall_cnt != CNT_MAX))
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    if (w_flush && (r_flush_cnt != CNT_MAX))
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                end
                default: begin
                    r_state     <= BOOT;
                    r_boot_cnt  <= BOOT_INIT;
                    r_busy_boot <= 1'b1;
                end
            endcase
        end
    end

    assign STALL_CNT = r_stall_cnt;
    assign FLUSH_CNT = r_flush_cnt;
    assign BUSY_BOOT = r_busy_boot;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    typedef struct {
        logic       rst;
        logic [4:0] ra, rb, rd;
        logic       use_ra, use_rb, use_rd;
        logic [4:0] ex_rd;
        logic       ex_le, ex_l;
        logic [4:0] mem_rd;
        logic       mem_le;
        logic [4:0] wb_rd;
        logic       wb_le;
        logic       taken;
    } in_t;

    typedef struct {
        string name;
        int    pc, le, clr, nop, fra, frb, frd, sc, fc, busy;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [4:0]    ID_RA, ID_RB, ID_RD, EX_RD, MEM_RD, WB_RD;
    logic          ID_USE_RA, ID_USE_RB, ID_USE_RD;
    logic          EX_RF_LE, EX_L, MEM_RF_LE, WB_RF_LE, EX_TAKEN;
    logic          PC_LE, IF_ID_LE, IF_ID_CLR, CU_NOP, BUSY_BOOT;
    logic [1:0]    FWD_RA, FWD_RB, FWD_RD;
    logic [CW-1:0] STALL_CNT, FLUSH_CNT;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    pipeline_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst),
        .ID_RA(ID_RA), .ID_RB(ID_RB), .ID_RD(ID_RD),
        .ID_USE_RA(ID_USE_RA), .ID_USE_RB(ID_USE_RB), .ID_USE_RD(ID_USE_RD),
        .EX_RD(EX_RD), .EX_RF_LE(EX_RF_LE), .EX_L(EX_L),
        .MEM_RD(MEM_RD), .MEM_RF_LE(MEM_RF_LE),
        .WB_RD(WB_RD), .WB_RF_LE(WB_RF_LE),
        .EX_TAKEN(EX_TAKEN),
        .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_CLR(IF_ID_CLR), .CU_NOP(CU_NOP),
        .FWD_RA(FWD_RA), .FWD_RB(FWD_RB), .FWD_RD(FWD_RD),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT), .BUSY_BOOT(BUSY_BOOT)
    );

    always #5 Clk = ~Clk;

    function automatic in_t idle();
        in_t v;
        v = '{rst: 1'b0, ra: 5'd0, rb: 5'd0, rd: 5'd0, use_ra: 1'b0, use_rb: 1'b0,
              use_rd: 1'b0, ex_rd: 5'd0, ex_le: 1'b0, ex_l: 1'b0, mem_rd: 5'd0,
              mem_le: 1'b0, wb_rd: 5'd0, wb_le: 1'b0, taken: 1'b0};
        return v;
    endfunction

    function automatic exp_t e_boot(string n, int sc, int fc);
        exp_t e;
        e = '{name: n, pc: 0, le: 0, clr: 1, nop: 1, fra: 0, frb: 0, frd: 0,
              sc: sc, fc: fc, busy: 1};
        return e;
    endfunction

    function automatic exp_t e_run(string n, int sc, int fc);
        exp_t e;
        e = '{name: n, pc: 1, le: 1, clr: 0, nop: 0, fra: 0, frb: 0, frd: 0,
              sc: sc, fc: fc, busy: 0};
        return e;
    endfunction

    function automatic exp_t e_stall(string n, int sc, int fc);
        exp_t e;
        e = e_run(n, sc, fc);
        e.pc = 0; e.le = 0; e.nop = 1;
        return e;
    endfunction

    // Load-use hazard: load to r5 in EX, ID reads r5 on RA
    function automatic in_t lu_in();
        in_t v;
        v = idle();
        v.ex_l = 1'b1; v.ex_le = 1'b1; v.ex_rd = 5'd5;
        v.ra = 5'd5; v.use_ra = 1'b1;
        return v;
    endfunction

    // Drive one cycle of inputs; when chk is set, queue the expected outputs
    task automatic step(input in_t v, input bit chk, input exp_t e);
        @(posedge Clk);
        #1;
        Rst = v.rst;
        ID_RA = v.ra; ID_RB = v.rb; ID_RD = v.rd;
        ID_USE_RA = v.use_ra; ID_USE_RB = v.use_rb; ID_USE_RD = v.use_rd;
        EX_RD = v.ex_rd; EX_RF_LE = v.ex_le; EX_L = v.ex_l;
        MEM_RD = v.mem_rd; MEM_RF_LE = v.mem_le;
        WB_RD = v.wb_rd; WB_RF_LE = v.wb_le;
        EX_TAKEN = v.taken;
        if (chk) sb.push_back(e);
    endtask

    task automatic cmp(input string vec, input string fld, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", vec, fld, act, exp);
        end
    endtask

    // Monitor: compare the outputs for the vector at the head of the scoreboard
    always @(negedge Clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.name, "PC_LE",     int'(PC_LE),     e.pc);
            cmp(e.name, "IF_ID_LE",  int'(IF_ID_LE),  e.le);
            cmp(e.name, "IF_ID_CLR", int'(IF_ID_CLR), e.clr);
            cmp(e.name, "CU_NOP",    int'(CU_NOP),    e.nop);
            cmp(e.name, "FWD_RA",    int'(FWD_RA),    e.fra);
            cmp(e.name, "FWD_RB",    int'(FWD_RB),    e.frb);
            cmp(e.name, "FWD_RD",    int'(FWD_RD),    e.frd);
            cmp(e.name, "STALL_CNT", int'(STALL_CNT), e.sc);
            cmp(e.name, "FLUSH_CNT", int'(FLUSH_CNT), e.fc);
            cmp(e.name, "BUSY_BOOT", int'(BUSY_BOOT), e.busy);
        end
    end

    initial begin
        in_t  v;
        exp_t e;
        int   wait_cyc;

        // Reset cycle: the state before the first reset is undefined, so nothing is checked
        v = idle(); v.rst = 1'b1;
        step(v, 0, e_boot("rst", 0, 0));

        // Boot: two cycles held, hazard inputs ignored, counters frozen
        v = idle(); v.taken = 1'b1;
        step(v, 1, e_boot("boot0", 0, 0));
        v = lu_in();
        step(v, 1, e_boot("boot1", 0, 0));
        step(idle(), 1, e_run("run_first", 0, 0));

        // Load-use stall on RA; EX forward suppressed
        step(lu_in(), 1, e_stall("lu_stall", 0, 0));
        // Load now in MEM, EX holds a NOP
        v = idle(); v.ra = 5'd5; v.use_ra = 1'b1; v.mem_rd = 5'd5; v.mem_le = 1'b1;
        e = e_run("lu_mem_fwd", 1, 0); e.fra = 2;
        step(v, 1, e);

        // Forward priority on RB: EX > MEM > WB
        v = idle(); v.rb = 5'd7; v.use_rb = 1'b1;
        v.ex_rd = 5'd7; v.ex_le = 1'b1; v.mem_rd = 5'd7; v.mem_le = 1'b1;
        v.wb_rd = 5'd7; v.wb_le = 1'b1;
        e = e_run("fwd_ex", 1, 0); e.frb = 1;
        step(v, 1, e);
        v.ex_le = 1'b0;
        e = e_run("fwd_mem", 1, 0); e.frb = 2;
        step(v, 1, e);
        v.ex_le = 1'b1; v.rb = 5'd0; v.ex_rd = 5'd0; v.mem_rd = 5'd0; v.wb_rd = 5'd0;
        step(v, 1, e_run("fwd_r0", 1, 0));

        // Store data from WB; RA matches MEM but is not used
        v = idle(); v.rd = 5'd3; v.use_rd = 1'b1; v.wb_rd = 5'd3; v.wb_le = 1'b1;
        v.ra = 5'd4; v.mem_rd = 5'd4; v.mem_le = 1'b1;
        e = e_run("fwd_wb_rd", 1, 0); e.frd = 3;
        step(v, 1, e);

        // Load to r0 never stalls
        v = idle(); v.ex_l = 1'b1; v.ex_le = 1'b1; v.ra = 5'd0; v.use_ra = 1'b1;
        step(v, 1, e_run("lu_r0", 1, 0));

        // Load-use via the store-data field
        v = idle(); v.ex_l = 1'b1; v.ex_le = 1'b1; v.ex_rd = 5'd9; v.rd = 5'd9; v.use_rd = 1'b1;
        step(v, 1, e_stall("lu_rd", 1, 0));

        // Branch wins over load-use
        v = idle(); v.ex_l = 1'b1; v.ex_le = 1'b1; v.ex_rd = 5'd6;
        v.rb = 5'd6; v.use_rb = 1'b1; v.taken = 1'b1;
        e = e_run("br_over_lu", 2, 0); e.clr = 1; e.nop = 1;
        step(v, 1, e);
        step(idle(), 1, e_run("after_br", 2, 1));

        // Saturation: 20 back-to-back stalls, RB forwarded from WB meanwhile
        for (int k = 0; k < 20; k++) begin
            v = lu_in(); v.rb = 5'd8; v.use_rb = 1'b1; v.wb_rd = 5'd8; v.wb_le = 1'b1;
            e = e_stall($sformatf("sat%0d", k), (2 + k > 15) ? 15 : 2 + k, 1);
            e.frb = 3;
            step(v, 1, e);
        end
        step(idle(), 1, e_run("sat_hold", 15, 1));

        // Reset during a stall cycle
        v = lu_in(); v.rst = 1'b1;
        step(v, 1, e_stall("rst_in_stall", 15, 1));
        v = lu_in(); v.taken = 1'b1;
        step(v, 1, e_boot("reboot0", 0, 0));
        step(idle(), 1, e_boot("reboot1", 0, 0));
        step(lu_in(), 1, e_stall("rerun", 0, 0));
        step(idle(), 1, e_run("rerun_cnt", 1, 0));

        // Drain the scoreboard within a bounded number of cycles
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge Clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard controller for the five-stage PA-RISC pipeline. Each cycle it decides whether the PC and IF/ID registers load, stall or flush. It decides when the control-unit mux injects a NOP into ID/EX, and it selects operand forwarding sources for the RA, RB and store-data paths. It also runs the post-reset boot sequence and keeps saturating stall/flush event counters for the debug bench.

## Interface
Parameters:
- BOOT_CYCLES, 2, cycles after reset during which fetch is held and NOPs are injected (1..15)
- CNT_W, 16, width of the event counters

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset; synchronous, active-high
- ID_RA, ID_RB, ID_RD  in  5 each  source register fields of the instruction in ID (ID_RD = store-data source)
- ID_USE_RA, ID_USE_RB, ID_USE_RD  in  1 each  instruction in ID reads that field
- EX_RD  in  5  destination of instruction in EX
- EX_RF_LE, EX_L  in  1 each  EX writes RF / EX is a load
- MEM_RD, MEM_RF_LE  in  5, 1  destination and write enable in MEM
- WB_RD, WB_RF_LE  in  5, 1  destination and write enable in WB
- EX_TAKEN  in  1  branch/jump in EX resolved taken (B with condition true, or UB)
- PC_LE  out  1  load enable to both PC registers
- IF_ID_LE, IF_ID_CLR  out  1 each  IF/ID load / clear
- CU_NOP  out  1  select NOP control word into ID/EX
- FWD_RA, FWD_RB, FWD_RD  out  2 each  forwarding select: 0 = RF, 1 = EX, 2 = MEM, 3 = WB
- STALL_CNT, FLUSH_CNT  out  CNT_W each  saturating event counters
- BUSY_BOOT  out  1  high while in BOOT

## Operation
- FSM states: BOOT and RUN.
  - Rst moves the FSM to BOOT and loads the boot counter with BOOT_CYCLES-1.
  - BOOT decrements the boot counter each cycle and moves to RUN on the cycle the counter reads 0.
  - RUN is terminal until the next Rst.
- Outputs in BOOT: PC_LE=0, IF_ID_LE=0, IF_ID_CLR=1, CU_NOP=1, all FWD=0.
- RUN, hazard priority from highest to lowest:
  1. **Taken branch** (EX_TAKEN=1): PC_LE=1, IF_ID_LE=1, IF_ID_CLR=1, CU_NOP=1. Both younger instructions are squashed. FLUSH_CNT increments.
  2. **Load-use**: EX_L & EX_RF_LE & EX_RD≠0 & EX_RD matches any used ID source. Outputs PC_LE=0, IF_ID_LE=0, IF_ID_CLR=0, CU_NOP=1. STALL_CNT increments.
  3. **Otherwise**: PC_LE=1, IF_ID_LE=1, IF_ID_CLR=0, CU_NOP=0.
- Forwarding is computed per source and is valid in every RUN cycle, including stall cycles.
  - Priority is EX > MEM > WB > RF.
  - A stage matches only if its RF_LE=1 and its RD equals the source field.
  - Register 0 is hardwired zero and never forwarded, so the select is 0 for it.
  - EX forwarding is suppressed when EX_L=1; that case is the load-use stall.
  - The select is 0 whenever ID_USE_x=0.
- Counters saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Reset values, cycle after Rst is sampled high: state=BOOT, BOOT_CYCLES-1 in the boot counter, BUSY_BOOT=1, STALL_CNT=0, FLUSH_CNT=0. Combinational outputs show BOOT values.
- Boot length: the first RUN cycle is exactly BOOT_CYCLES cycles after Rst deasserts.
- Hazard and forwarding outputs are combinational from the inputs and the current state, with zero latency. Counters update on the following edge.
- A load-use stall lasts one cycle. On the next cycle the load sits in MEM with EX=NOP, so MEM forwarding resolves it.
- If EX_TAKEN and load-use occur in the same cycle, branch wins. Only FLUSH_CNT increments.
- Rst mid-stall or mid-flush aborts the event and returns to BOOT. Counters clear.
- Inputs are ignored in BOOT, and counters do not change there.

## Structure
- The shared package pipe_ctrl_pkg holds:
  - the state enum {BOOT, RUN}
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB constants
  - the register-0 constant
- One sub-module, fwd_select, is instantiated three times (RA, RB, RD). Its inputs are the source register, its use flag and the three stage RD/RF_LE pairs plus EX_L. Its output is the 2-bit select.
- The FSM, boot counter and event counters stay in the top module.

## Test plan
- **Boot**: Rst for 1 cycle, BOOT_CYCLES=2 → PC_LE=0 and CU_NOP=1 for 2 cycles, then PC_LE=1. BUSY_BOOT falls on the first RUN cycle.
- **Load-use**: EX_L=1, EX_RF_LE=1, EX_RD=5, ID_RA=5, ID_USE_RA=1 → one cycle with PC_LE=0, IF_ID_LE=0, CU_NOP=1, STALL_CNT 0→1. The next cycle (MEM_RD=5, MEM_RF_LE=1) gives FWD_RA=2 and no stall.
- **Forward priority**: EX_RD=MEM_RD=WB_RD=7, all RF_LE=1, EX_L=0, ID_RB=7 → FWD_RB=1. Drop EX_RF_LE → FWD_RB=2. Set ID_RB=0 with all RD=0 → FWD_RB=0.
- **Branch over load-use**: EX_TAKEN=1 together with a load-use match → IF_ID_CLR=1, CU_NOP=1, PC_LE=1. FLUSH_CNT increments and STALL_CNT is unchanged.
- **Counter saturation**: CNT_W=4, 20 consecutive load-use cycles → STALL_CNT holds at 15.
- **Reset mid-operation**: assert Rst during a stall cycle → next cycle is BOOT and both counters read 0.
